// File: rtl/axis_mm_stream_ctrl.sv
// AXI-Stream controller between the DMA streams and the matrix-multiply core:
// loads weight/input BRAMs, starts the core and drains results through a 2-entry skid buffer.
// Optional cycle counters are enabled with `define AXIS_MM_PERF_CNT_EN.
module axis_mm_stream_ctrl #(
  parameter int WIDTH       = 16,
  parameter int CHUNK_SIZE  = 4,
  parameter int NUM_CORES   = 2,
  parameter int NUM_W_WORDS = 6,
  parameter int NUM_I_WORDS = 4,
  parameter int NUM_O_WORDS = 6,
  parameter int W_ADDR_W    = 3,
  parameter int I_ADDR_W    = 2,
  parameter int O_ADDR_W    = 3
) (
  input  logic                                  aclk,
  input  logic                                  areset,
  input  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] s_axis_i_tdata,
  input  logic                                  s_axis_i_tvalid,
  input  logic                                  s_axis_i_tlast,
  output logic                                  s_axis_i_tready,
  input  logic [WIDTH*CHUNK_SIZE-1:0]           s_axis_w_tdata,
  input  logic                                  s_axis_w_tvalid,
  input  logic                                  s_axis_w_tlast,
  output logic                                  s_axis_w_tready,
  output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] m_axis_tdata,
  output logic                                  m_axis_tvalid,
  output logic                                  m_axis_tlast,
  input  logic                                  m_axis_tready,
  output logic                                  wb_ena,
  output logic [WIDTH*CHUNK_SIZE/8-1:0]         wb_wea,
  output logic [W_ADDR_W-1:0]                   wb_addra,
  output logic [WIDTH*CHUNK_SIZE-1:0]           wb_dina,
  output logic                                  in_ena,
  output logic [WIDTH*CHUNK_SIZE*NUM_CORES/8-1:0] in_wea,
  output logic [I_ADDR_W-1:0]                   in_addra,
  output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] in_dina,
  output logic                                  core_start,
  input  logic                                  core_done,
  output logic                                  out_enb,
  output logic [O_ADDR_W-1:0]                   out_addrb,
  input  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] out_doutb,
  input  logic                                  cfg_keep_w,
  output logic                                  busy,
  output logic                                  err_tlast,
  input  logic                                  err_clr
`ifdef AXIS_MM_PERF_CNT_EN
  ,
  output logic [31:0]                           perf_load_cycles,
  output logic [31:0]                           perf_run_cycles,
  output logic [31:0]                           perf_drain_cycles
`endif
);

  localparam int WW = WIDTH * CHUNK_SIZE;
  localparam int IW = WW * NUM_CORES;
  localparam logic [W_ADDR_W:0] W_LAST = (W_ADDR_W+1)'(NUM_W_WORDS - 1);
  localparam logic [I_ADDR_W:0] I_LAST = (I_ADDR_W+1)'(NUM_I_WORDS - 1);
  localparam logic [O_ADDR_W:0] O_LAST = (O_ADDR_W+1)'(NUM_O_WORDS - 1);
  localparam logic [O_ADDR_W:0] O_NUM  = (O_ADDR_W+1)'(NUM_O_WORDS);
  localparam logic [W_ADDR_W:0] W_ONE  = (W_ADDR_W+1)'(1);
  localparam logic [I_ADDR_W:0] I_ONE  = (I_ADDR_W+1)'(1);
  localparam logic [O_ADDR_W:0] O_ONE  = (O_ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                skip_w_q, w_done_q, i_done_q, weights_valid_q, err_tlast_q;
  logic [W_ADDR_W:0]   w_cnt_q;
  logic [I_ADDR_W:0]   i_cnt_q;
  logic [O_ADDR_W:0]   rd_cnt_q, tx_cnt_q;
  logic                inflight_q, wr_ptr_q, rd_ptr_q;
  logic [1:0]          occ_q;
  logic [IW-1:0]       buf_q [0:1];
  logic                keep_s, w_hs_s, i_hs_s, w_err_s, i_err_s, pop_s, last_tx_s, issue_s;
  logic [2:0]          level_s;

  assign keep_s    = cfg_keep_w & weights_valid_q;
  assign w_hs_s    = s_axis_w_tvalid & s_axis_w_tready;
  assign i_hs_s    = s_axis_i_tvalid & s_axis_i_tready;
  assign w_err_s   = w_hs_s & (s_axis_w_tlast != (w_cnt_q == W_LAST));
  assign i_err_s   = i_hs_s & (s_axis_i_tlast != (i_cnt_q == I_LAST));
  assign wb_ena    = w_hs_s;
  assign wb_wea    = {(WW/8){w_hs_s}};
  assign wb_addra  = w_cnt_q[W_ADDR_W-1:0];
  assign wb_dina   = s_axis_w_tdata;
  assign in_ena    = i_hs_s;
  assign in_wea    = {(IW/8){i_hs_s}};
  assign in_addra  = i_cnt_q[I_ADDR_W-1:0];
  assign in_dina   = s_axis_i_tdata;

  // Skid buffer: a read may issue only if the beat leaving this cycle frees room for it.
  assign m_axis_tvalid = (occ_q != 2'd0);
  assign m_axis_tdata  = buf_q[rd_ptr_q];
  assign last_tx_s     = (tx_cnt_q == O_LAST);
  assign m_axis_tlast  = m_axis_tvalid & last_tx_s;
  assign pop_s         = m_axis_tvalid & m_axis_tready;
  assign level_s       = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign issue_s       = (state_q == S_DRAIN) && (rd_cnt_q < O_NUM) && (level_s < 3'd2);
  assign out_enb       = issue_s;
  assign out_addrb     = rd_cnt_q[O_ADDR_W-1:0];
  assign busy          = (state_q != S_IDLE);
  assign err_tlast     = err_tlast_q;

  always_comb begin
    state_d         = state_q;
    s_axis_w_tready = 1'b0;
    s_axis_i_tready = 1'b0;
    core_start      = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: begin
        s_axis_w_tready = !w_done_q && !skip_w_q;
        s_axis_i_tready = !i_done_q;
        if (w_done_q && i_done_q) state_d = S_START;
        else                      state_d = S_LOAD;
      end
      S_START: begin
        core_start = 1'b1;
        state_d    = S_RUN;
      end
      S_RUN: begin
        if (core_done) state_d = S_DRAIN;
        else           state_d = S_RUN;
      end
      S_DRAIN: begin
        if (pop_s && last_tx_s) state_d = S_IDLE;
        else                    state_d = S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q         <= S_IDLE;
      skip_w_q        <= 1'b0;
      w_done_q        <= 1'b0;
      i_done_q        <= 1'b0;
      weights_valid_q <= 1'b0;
      w_cnt_q         <= '0;
      i_cnt_q         <= '0;
      rd_cnt_q        <= '0;
      tx_cnt_q        <= '0;
      inflight_q      <= 1'b0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      occ_q           <= 2'd0;
      buf_q[0]        <= '0;
      buf_q[1]        <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          skip_w_q   <= keep_s;
          w_done_q   <= keep_s;
          i_done_q   <= 1'b0;
          w_cnt_q    <= '0;
          i_cnt_q    <= '0;
          rd_cnt_q   <= '0;
          tx_cnt_q   <= '0;
          inflight_q <= 1'b0;
          wr_ptr_q   <= 1'b0;
          rd_ptr_q   <= 1'b0;
          occ_q      <= 2'd0;
          if (!keep_s) weights_valid_q <= 1'b0;
        end
        S_LOAD: begin
          if (w_hs_s) begin
            w_cnt_q <= w_cnt_q + W_ONE;
            if (w_cnt_q == W_LAST) begin
              w_done_q        <= 1'b1;
              weights_valid_q <= 1'b1;
            end
          end
          if (i_hs_s) begin
            i_cnt_q <= i_cnt_q + I_ONE;
            if (i_cnt_q == I_LAST) i_done_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          inflight_q <= issue_s;
          if (issue_s) rd_cnt_q <= rd_cnt_q + O_ONE;
          if (inflight_q) begin
            buf_q[wr_ptr_q] <= out_doutb;
            wr_ptr_q        <= ~wr_ptr_q;
          end
          if (pop_s) begin
            rd_ptr_q <= ~rd_ptr_q;
            tx_cnt_q <= tx_cnt_q + O_ONE;
          end
          occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop_s};
        end
        default: ;
      endcase
    end
  end

  // A new mismatch takes priority over a clear in the same cycle.
  always_ff @(posedge aclk) begin
    if (areset)                  err_tlast_q <= 1'b0;
    else if (w_err_s || i_err_s) err_tlast_q <= 1'b1;
    else if (err_clr)            err_tlast_q <= 1'b0;
    else                         err_tlast_q <= err_tlast_q;
  end

`ifdef AXIS_MM_PERF_CNT_EN
  logic [31:0] load_cyc_q, run_cyc_q, drain_cyc_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Per-job phase counters, published when the drain completes.
  always_ff @(posedge aclk) begin
    if (areset) begin
      load_cyc_q        <= 32'd0;
      run_cyc_q         <= 32'd0;
      drain_cyc_q       <= 32'd0;
      perf_load_cycles  <= 32'd0;
      perf_run_cycles   <= 32'd0;
      perf_drain_cycles <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          load_cyc_q  <= 32'd0;
          run_cyc_q   <= 32'd0;
          drain_cyc_q <= 32'd0;
        end
        S_LOAD: load_cyc_q <= sat_inc(load_cyc_q);
        S_RUN:  run_cyc_q  <= sat_inc(run_cyc_q);
        S_DRAIN: begin
          drain_cyc_q <= sat_inc(drain_cyc_q);
          if (state_d == S_IDLE) begin
            perf_load_cycles  <= load_cyc_q;
            perf_run_cycles   <= run_cyc_q;
            perf_drain_cycles <= sat_inc(drain_cyc_q);
          end
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_axis_mm_stream_ctrl.sv
// Directed self-checking bench for axis_mm_stream_ctrl with a small core/output-BRAM model.
`timescale 1ns/1ps
module tb_axis_mm_stream_ctrl;
  localparam int NW = 6, NI = 4, NO = 6;

  logic         aclk = 1'b0;
  logic         areset;
  logic [127:0] s_axis_i_tdata;
  logic         s_axis_i_tvalid, s_axis_i_tlast, s_axis_i_tready;
  logic [63:0]  s_axis_w_tdata;
  logic         s_axis_w_tvalid, s_axis_w_tlast, s_axis_w_tready;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic         wb_ena;
  logic [7:0]   wb_wea;
  logic [2:0]   wb_addra;
  logic [63:0]  wb_dina;
  logic         in_ena;
  logic [15:0]  in_wea;
  logic [1:0]   in_addra;
  logic [127:0] in_dina;
  logic         core_start, core_done;
  logic         out_enb;
  logic [2:0]   out_addrb;
  logic [127:0] out_doutb;
  logic         cfg_keep_w, busy, err_tlast, err_clr;

  always #5 aclk = ~aclk;

  axis_mm_stream_ctrl dut (
    .aclk(aclk), .areset(areset),
    .s_axis_i_tdata(s_axis_i_tdata), .s_axis_i_tvalid(s_axis_i_tvalid),
    .s_axis_i_tlast(s_axis_i_tlast), .s_axis_i_tready(s_axis_i_tready),
    .s_axis_w_tdata(s_axis_w_tdata), .s_axis_w_tvalid(s_axis_w_tvalid),
    .s_axis_w_tlast(s_axis_w_tlast), .s_axis_w_tready(s_axis_w_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .wb_ena(wb_ena), .wb_wea(wb_wea), .wb_addra(wb_addra), .wb_dina(wb_dina),
    .in_ena(in_ena), .in_wea(in_wea), .in_addra(in_addra), .in_dina(in_dina),
    .core_start(core_start), .core_done(core_done),
    .out_enb(out_enb), .out_addrb(out_addrb), .out_doutb(out_doutb),
    .cfg_keep_w(cfg_keep_w), .busy(busy), .err_tlast(err_tlast), .err_clr(err_clr)
  );

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wdat(input int j, input int k);
    return {16'hC0DE, 16'(j), 16'hBEEF, 16'(k)};
  endfunction
  function automatic logic [127:0] idat(input int j, input int k);
    return {16'hABCD, 16'(j), 16'h0001, 16'(k), 64'h0123_4567_89AB_CDEF};
  endfunction
  function automatic logic [127:0] odat(input int j, input int k);
    return {16'hF00D, 16'(j), 16'(k), 16'h7777, 64'(k) * 64'h1111_0000_1111};
  endfunction

  // Core model: done pulse a few cycles after start; output BRAM with 1-cycle read latency.
  logic [127:0] omem [0:7];
  int dly;
  always @(posedge aclk) begin
    if (areset) begin
      dly       <= 0;
      core_done <= 1'b0;
    end else begin
      core_done <= (dly == 1);
      if (core_start)    dly <= 5;
      else if (dly != 0) dly <= dly - 1;
    end
    if (out_enb) out_doutb <= omem[out_addrb];
  end

  // Monitor: logs BRAM writes, reads, output beats and stall stability once per cycle.
  int clr_gen = 0, seen_gen = 0, cyc = 0;
  logic [2:0]   wa_log [16];
  logic [63:0]  wd_log [16];
  logic [1:0]   ia_log [16];
  logic [127:0] id_log [16];
  logic [2:0]   oa_log [16];
  logic [127:0] ob_d   [16];
  logic         ob_l   [16];
  int           ob_cyc [16];
  int n_w, n_i, n_rd, n_ob, n_start, w_rdy_seen, wea_bad, stall_bad, max_out, enb_cyc0;
  logic         prev_stall, prev_l;
  logic [127:0] prev_d;
  always @(negedge aclk) begin
    #2;
    cyc++;
    if (seen_gen != clr_gen) begin
      seen_gen = clr_gen;
      n_w = 0; n_i = 0; n_rd = 0; n_ob = 0; n_start = 0; w_rdy_seen = 0;
      wea_bad = 0; stall_bad = 0; max_out = 0; enb_cyc0 = 0; prev_stall = 1'b0;
    end
    if (wb_ena) begin
      if (n_w < 16) begin wa_log[n_w] = wb_addra; wd_log[n_w] = wb_dina; end
      if (wb_wea != 8'hFF) wea_bad++;
      n_w++;
    end
    if (in_ena) begin
      if (n_i < 16) begin ia_log[n_i] = in_addra; id_log[n_i] = in_dina; end
      if (in_wea != 16'hFFFF) wea_bad++;
      n_i++;
    end
    if (core_start) n_start++;
    if (s_axis_w_tready) w_rdy_seen++;
    if (out_enb) begin
      if (n_rd == 0) enb_cyc0 = cyc;
      if (n_rd < 16) oa_log[n_rd] = out_addrb;
      n_rd++;
    end
    if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l))
      stall_bad++;
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_d     = m_axis_tdata;
    prev_l     = m_axis_tlast;
    if (m_axis_tvalid && m_axis_tready) begin
      if (n_ob < 16) begin ob_d[n_ob] = m_axis_tdata; ob_l[n_ob] = m_axis_tlast; ob_cyc[n_ob] = cyc; end
      n_ob++;
    end
    if (n_rd - n_ob > max_out) max_out = n_rd - n_ob;
  end

  task automatic drive_w(input int j, input bit gap);
    int k = 0, guard = 0;
    bit hold = 1'b0;
    while (k < NW && guard < 400) begin
      @(negedge aclk); guard++;
      if (!hold) begin
        s_axis_w_tvalid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
        s_axis_w_tdata  = wdat(j, k);
        s_axis_w_tlast  = (k == NW - 1);
      end
      #1;
      if (s_axis_w_tvalid && s_axis_w_tready) begin k++; hold = 1'b0; end
      else hold = s_axis_w_tvalid;
    end
    @(negedge aclk);
    s_axis_w_tvalid = 1'b0;
    s_axis_w_tlast  = 1'b0;
    chk("w_beats_sent", 128'(k), 128'(NW));
  endtask

  task automatic drive_i(input int j, input bit gap, input int err_beat);
    int k = 0, guard = 0;
    bit hold = 1'b0;
    while (k < NI && guard < 400) begin
      @(negedge aclk); guard++;
      if (!hold) begin
        s_axis_i_tvalid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
        s_axis_i_tdata  = idat(j, k);
        s_axis_i_tlast  = (k == NI - 1) || (k == err_beat);
      end
      #1;
      if (s_axis_i_tvalid && s_axis_i_tready) begin k++; hold = 1'b0; end
      else hold = s_axis_i_tvalid;
    end
    @(negedge aclk);
    s_axis_i_tvalid = 1'b0;
    s_axis_i_tlast  = 1'b0;
    chk("i_beats_sent", 128'(k), 128'(NI));
  endtask

  // mode 0: always ready, 1: random ready, 2: ready low for 10 cycles after 2 beats.
  task automatic sink(input int mode, input int stop_at);
    int guard = 0, stall = 0;
    while (n_ob < stop_at && guard < 400) begin
      @(negedge aclk); guard++;
      if (n_ob >= stop_at) break;
      case (mode)
        1: m_axis_tready = 1'($urandom_range(0, 1));
        2: begin
          if (n_ob >= 2 && stall < 10) begin m_axis_tready = 1'b0; stall++; end
          else m_axis_tready = 1'b1;
        end
        default: m_axis_tready = 1'b1;
      endcase
    end
    m_axis_tready = 1'b0;
    chk("out_beats_taken", 128'(n_ob), 128'(stop_at));
  endtask

  task automatic run_job(input int j, input bit keep, input bit gap, input int bp,
                         input int err_beat, input bit next_keep, input int stop_at);
    clr_gen++;
    for (int a = 0; a < 8; a++) omem[a] = odat(j, a);
    if (keep) begin
      s_axis_w_tvalid = 1'b1;
      s_axis_w_tdata  = wdat(j, 0);
      s_axis_w_tlast  = 1'b0;
      drive_i(j, gap, err_beat);
      s_axis_w_tvalid = 1'b0;
    end else begin
      fork
        drive_w(j, gap);
        drive_i(j, gap, err_beat);
      join
    end
    cfg_keep_w = next_keep;
    sink(bp, stop_at);
  endtask

  task automatic check_job(input int j, input int n_w_exp);
    chk("wb_count", 128'(n_w), 128'(n_w_exp));
    for (int k = 0; k < n_w_exp; k++) begin
      chk("wb_addr", 128'(wa_log[k]), 128'(k));
      chk("wb_data", 128'(wd_log[k]), 128'(wdat(j, k)));
    end
    chk("in_count", 128'(n_i), 128'(NI));
    for (int k = 0; k < NI; k++) begin
      chk("in_addr", 128'(ia_log[k]), 128'(k));
      chk("in_data", id_log[k], idat(j, k));
    end
    chk("start_pulses", 128'(n_start), 128'(1));
    chk("wea_all_ones", 128'(wea_bad), 128'(0));
    chk("out_count", 128'(n_ob), 128'(NO));
    for (int k = 0; k < NO; k++) begin
      chk("rd_addr", 128'(oa_log[k]), 128'(k));
      chk("out_data", ob_d[k], odat(j, k));
      chk("out_last", 128'(ob_l[k]), 128'(k == NO - 1));
    end
    chk("stall_stable", 128'(stall_bad), 128'(0));
    chk("outstanding_le2", 128'(max_out <= 2), 128'(1));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_w_tready"}, 128'(s_axis_w_tready), 128'(0));
    chk({tag, "_i_tready"}, 128'(s_axis_i_tready), 128'(0));
    chk({tag, "_m_tvalid"}, 128'(m_axis_tvalid), 128'(0));
    chk({tag, "_m_tlast"},  128'(m_axis_tlast), 128'(0));
    chk({tag, "_wb_ena"},   128'(wb_ena), 128'(0));
    chk({tag, "_wb_wea"},   128'(wb_wea), 128'(0));
    chk({tag, "_in_ena"},   128'(in_ena), 128'(0));
    chk({tag, "_in_wea"},   128'(in_wea), 128'(0));
    chk({tag, "_start"},    128'(core_start), 128'(0));
    chk({tag, "_out_enb"},  128'(out_enb), 128'(0));
    chk({tag, "_busy"},     128'(busy), 128'(0));
    chk({tag, "_err"},      128'(err_tlast), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1; cfg_keep_w = 1'b0; err_clr = 1'b0; m_axis_tready = 1'b0;
    s_axis_w_tvalid = 1'b0; s_axis_w_tlast = 1'b0; s_axis_w_tdata = '0;
    s_axis_i_tvalid = 1'b0; s_axis_i_tlast = 1'b0; s_axis_i_tdata = '0;
    repeat (3) @(negedge aclk);
    #1 chk_idle("reset");
    areset = 1'b0;

    // Job 1: streams always valid, sink always ready.
    run_job(1, 1'b0, 1'b0, 0, -1, 1'b0, NO);
    #1 chk("j1_busy_after", 128'(busy), 128'(0));
    check_job(1, NW);
    chk("j1_back_to_back", 128'(ob_cyc[NO-1] - ob_cyc[0]), 128'(NO - 1));
    chk("j1_first_beat_lat", 128'(ob_cyc[0] - enb_cyc0), 128'(2));
    chk("j1_no_err", 128'(err_tlast), 128'(0));

    // Job 2: random gaps on all streams; next job keeps weights.
    run_job(2, 1'b0, 1'b1, 1, -1, 1'b1, NO);
    #1 chk("j2_busy_after", 128'(busy), 128'(0));
    check_job(2, NW);

    // Job 3: resident weights reused, 10-cycle backpressure stall mid-drain.
    run_job(3, 1'b1, 1'b0, 2, -1, 1'b1, NO);
    check_job(3, 0);
    chk("j3_w_tready_never", 128'(w_rdy_seen), 128'(0));
    chk("j3_skid_full", 128'(max_out), 128'(2));

    // Reset forgets the resident weights even with keep requested; input tlast early on beat 1.
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    run_job(4, 1'b0, 1'b0, 0, 1, 1'b0, NO);
    check_job(4, NW);
    chk("j4_err_set", 128'(err_tlast), 128'(1));
    @(negedge aclk) err_clr = 1'b1;
    @(negedge aclk) err_clr = 1'b0;
    #1 chk("j4_err_cleared", 128'(err_tlast), 128'(0));

    // Job 5: reset after three drained beats, then job 6 must run cleanly.
    run_job(5, 1'b0, 1'b0, 0, -1, 1'b0, 3);
    areset = 1'b1;
    @(negedge aclk);
    #1 chk_idle("mid_drain_reset");
    areset = 1'b0;
    run_job(6, 1'b0, 1'b1, 0, -1, 1'b0, NO);
    #1 chk("j6_busy_after", 128'(busy), 128'(0));
    check_job(6, NW);
    chk("j6_no_err", 128'(err_tlast), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
